keypad_entry_ctrl: RTL and testbench
====================================

// Module: keypad_entry_ctrl
// PURPOSE
//  Sequences calculator operand/operator entry from the keypad scanner's keycode/keypressed.
//  Debounces and edge-detects key presses, then accumulates BCD operands and the operator.
//  Issues one valid/ready request to the arithmetic unit per calculation and captures its result.
//  Drives the BCD value and flags that the char_7seg display chain shows.
// PARAMETERS
//  DIGITS           4  BCD digits per operand/result (bus width 4*DIGITS)
//  DEBOUNCE_CYCLES  3  consecutive identical samples needed to accept a press or a release
// PORTS
//  clock         in   1          system clock; all logic on rising edge
//  reset         in   1          synchronous, active-high
//  keycode       in   4          key code from keypadscanner
//  keypressed    in   1          key-held flag from keypadscanner
//  operand_a     out  4*DIGITS   BCD operand A
//  operand_b     out  4*DIGITS   BCD operand B
//  opcode        out  2          00 add, 01 sub, 10 mul
//  calc_valid    out  1          request to arithmetic unit
//  calc_ready    in   1          arithmetic unit accepts request
//  result_valid  in   1          one-cycle result strobe
//  result_bcd    in   4*DIGITS   BCD magnitude of result
//  result_neg    in   1          result is negative
//  result_err    in   1          overflow / invalid result
//  display_bcd   out  4*DIGITS   value to show
//  display_neg   out  1          show minus sign
//  display_err   out  1          show error pattern
// BEHAVIOUR
//  Reset: state S_A; operand_a/b, display_bcd = 0; opcode = 00; calc_valid, display_neg, display_err = 0.
//  Key map: 0-9 digit; A add; B sub; C mul; D equals; E clear; F backspace.
//  Debounce: a press is accepted after keypressed=1 with an unchanged keycode for DEBOUNCE_CYCLES samples.
//   A keycode change while held restarts the count.
//   Exactly one key_strobe per press.
//   Re-arm requires keypressed=0 for DEBOUNCE_CYCLES samples.
//   Registers update on the edge after the strobe; total latency = DEBOUNCE_CYCLES+1 clocks.
//  Digit append: shift left one digit, new digit into LSD.
//   Ignored if the MSD is already nonzero.
//   0 entered onto a zero operand leaves 0.
//  Backspace: shift right one digit, MSD := 0.
//  States and transitions:
//   S_A: digit appends to A. Op stores opcode, goes to S_OP. Backspace edits A. Equals ignored.
//   S_OP: digit sets B := digit, goes to S_B. Op replaces opcode. Backspace returns to S_A. Equals ignored.
//   S_B: digit appends to B; backspace edits B; op ignored. Equals sets calc_valid=1, goes to S_REQ.
//   S_REQ: calc_valid held; operand_a/b and opcode stable until calc_valid & calc_ready, then S_BUSY.
//   S_BUSY: on result_valid, capture result; go to S_ERR if result_err, else S_RES.
//   S_RES: display shows result. Digit sets A := digit and B := 0, goes to S_A. Op per CONFIGURATION.
//   S_ERR: display_err=1; only clear exits.
//  Clear (any state): zero A, B and display; opcode=00; calc_valid=0; go to S_A.
//   A clear in S_REQ aborts the request.
//  In S_REQ and S_BUSY, all keys except clear are dropped, not queued.
//  result_valid outside S_BUSY is ignored; calc_ready outside S_REQ is ignored.
//  Display: S_A shows A; S_OP shows A; S_B shows B; S_REQ and S_BUSY show B.
//   S_RES shows result_bcd plus result_neg. display_neg = 0 except in S_RES.
// CONFIGURATION
//  CALC_CHAIN_EN defined: op key in S_RES sets A := result, stores opcode, goes to S_OP.
//   The sign is dropped: a negative result enters as its magnitude.
//  CALC_CHAIN_EN undefined: op key in S_RES is ignored.
// STRUCTURE
//  calc_pkg: keycode constants KEY_ADD..KEY_BKSP, opcode constants OP_ADD/SUB/MUL, state encoding.
//  Sub-module key_debounce: (clock, reset, keycode, keypressed) -> key_strobe, key_value[3:0].
//  Top level holds the entry FSM, operand shifters and the display mux.
// TESTING
//  1. Press 1,2,A,7,D; calc_ready=1. Expect A=0x0012, B=0x0007, opcode 00, calc_valid for 1 cycle.
//     Then result_valid with 0x0019: display 0x0019 in S_RES.
//  2. Glitch keypressed for 2 cycles (DEBOUNCE_CYCLES=3). Expect no strobe; operand_a unchanged.
//  3. Hold key 5 for 50 cycles. Expect one digit only (A=0x0005).
//  4. Enter 9,8,7,6,5. Expect A=0x9876. Then F gives 0x0987.
//  5. Hold calc_ready=0 for 10 cycles in S_REQ. Expect calc_valid high with operands stable.
//     Then press E: calc_valid=0, state S_A, display 0.
//  6. result_err=1: display_err=1, digit keys ignored, E clears.
//     With CALC_CHAIN_EN, result 0x0019 then B gives A=0x0019, opcode 01, S_OP.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared keycodes, opcodes and entry-FSM state encoding for the keypad calculator front end.
package calc_pkg;

    localparam logic [3:0] KEY_ADD  = 4'hA;
    localparam logic [3:0] KEY_SUB  = 4'hB;
    localparam logic [3:0] KEY_MUL  = 4'hC;
    localparam logic [3:0] KEY_EQ   = 4'hD;
    localparam logic [3:0] KEY_CLR  = 4'hE;
    localparam logic [3:0] KEY_BKSP = 4'hF;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;

    typedef enum logic [2:0] {
        S_A,
        S_OP,
        S_B,
        S_REQ,
        S_BUSY,
        S_RES,
        S_ERR
    } state_t;

    function automatic logic [1:0] key_to_op(input logic [3:0] key);
        case (key)
            KEY_SUB: return OP_SUB;
            KEY_MUL: return OP_MUL;
            default: return OP_ADD;
        endcase
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Press/release debouncer: one key_strobe per accepted press, re-armed only after a stable release.
module key_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] keycode,
    input  logic       keypressed,
    output logic       key_strobe,
    output logic [3:0] key_value
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             armed_q, armed_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       code_q, code_d;
    logic             strobe_q, strobe_d;
    logic [3:0]       value_q, value_d;

    always_comb begin
        armed_d  = armed_q;
        cnt_d    = cnt_q;
        code_d   = code_q;
        strobe_d = 1'b0;
        value_d  = value_q;
        if (armed_q) begin
            if (keypressed) begin
                // a different code while held restarts the stability count
                code_d = keycode;
                if (cnt_q != '0 && keycode == code_q) cnt_d = cnt_q + CNT_ONE;
                else                                  cnt_d = CNT_ONE;
                if (cnt_d == CNT_DONE) begin
                    strobe_d = 1'b1;
                    value_d  = keycode;
                    armed_d  = 1'b0;
                    cnt_d    = '0;
                end
            end else begin
                cnt_d = '0;
            end
        end else begin
            if (!keypressed) begin
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_d == CNT_DONE) begin
                    armed_d = 1'b1;
                    cnt_d   = '0;
                end
            end else begin
                cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            armed_q  <= 1'b1;
            cnt_q    <= '0;
            code_q   <= '0;
            strobe_q <= 1'b0;
            value_q  <= '0;
        end else begin
            armed_q  <= armed_d;
            cnt_q    <= cnt_d;
            code_q   <= code_d;
            strobe_q <= strobe_d;
            value_q  <= value_d;
        end
    end

    assign key_strobe = strobe_q;
    assign key_value  = value_q;

endmodule

// File: rtl/keypad_entry_ctrl.sv
// Calculator entry FSM: BCD operand shifters, one request per calculation, result capture, display mux.
// Define CALC_CHAIN_EN to let an operator key after a result continue with that result as operand A.
module keypad_entry_ctrl
    import calc_pkg::*;
#(
    parameter int unsigned DIGITS          = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [3:0]            keycode,
    input  logic                  keypressed,
    output logic [4*DIGITS-1:0]   operand_a,
    output logic [4*DIGITS-1:0]   operand_b,
    output logic [1:0]            opcode,
    output logic                  calc_valid,
    input  logic                  calc_ready,
    input  logic                  result_valid,
    input  logic [4*DIGITS-1:0]   result_bcd,
    input  logic                  result_neg,
    input  logic                  result_err,
    output logic [4*DIGITS-1:0]   display_bcd,
    output logic                  display_neg,
    output logic                  display_err
);

    localparam int unsigned W = 4 * DIGITS;

    logic         key_strobe;
    logic [3:0]   key_value;
    logic         is_digit, is_op;
    logic [W-1:0] digit_ext;

    state_t       state_q, state_d;
    logic [W-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic [1:0]   op_q, op_d;
    logic         res_neg_q, res_neg_d;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
        .clock      (clock),
        .reset      (reset),
        .keycode    (keycode),
        .keypressed (keypressed),
        .key_strobe (key_strobe),
        .key_value  (key_value)
    );

    function automatic logic [W-1:0] append_digit(input logic [W-1:0] v, input logic [3:0] d);
        if (v[W-1 -: 4] != 4'd0) return v;
        return {v[W-5:0], d};
    endfunction

    function automatic logic [W-1:0] drop_digit(input logic [W-1:0] v);
        return {4'd0, v[W-1:4]};
    endfunction

    assign is_digit  = (key_value <= 4'd9);
    assign is_op     = (key_value == KEY_ADD) || (key_value == KEY_SUB) || (key_value == KEY_MUL);
    assign digit_ext = {{(W-4){1'b0}}, key_value};

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        res_d     = res_q;
        res_neg_d = res_neg_q;

        // handshake and result capture first; a same-cycle clear overrides both below
        case (state_q)
            S_REQ:  if (calc_ready) state_d = S_BUSY;
            S_BUSY: if (result_valid) begin
                res_d     = result_bcd;
                res_neg_d = result_neg;
                state_d   = result_err ? S_ERR : S_RES;
            end
            default: ;
        endcase

        if (key_strobe) begin
            if (key_value == KEY_CLR) begin
                a_d       = '0;
                b_d       = '0;
                op_d      = OP_ADD;
                res_d     = '0;
                res_neg_d = 1'b0;
                state_d   = S_A;
            end else begin
                case (state_q)
                    S_A: begin
                        if (is_digit) a_d = append_digit(a_q, key_value);
                        else if (is_op) begin
                            op_d    = key_to_op(key_value);
                            state_d = S_OP;
                        end else if (key_value == KEY_BKSP) a_d = drop_digit(a_q);
                    end
                    S_OP: begin
                        if (is_digit) begin
                            b_d     = digit_ext;
                            state_d = S_B;
                        end else if (is_op) op_d = key_to_op(key_value);
                        else if (key_value == KEY_BKSP) state_d = S_A;
                    end
                    S_B: begin
                        if (is_digit) b_d = append_digit(b_q, key_value);
                        else if (key_value == KEY_BKSP) b_d = drop_digit(b_q);
                        else if (key_value == KEY_EQ) state_d = S_REQ;
                    end
                    S_RES: begin
                        if (is_digit) begin
                            a_d     = digit_ext;
                            b_d     = '0;
                            state_d = S_A;
                        end
`ifdef CALC_CHAIN_EN
                        else if (is_op) begin
                            a_d     = res_q;
                            op_d    = key_to_op(key_value);
                            state_d = S_OP;
                        end
`endif
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_A;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= OP_ADD;
            res_q     <= '0;
            res_neg_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            op_q      <= op_d;
            res_q     <= res_d;
            res_neg_q <= res_neg_d;
        end
    end

    always_comb begin
        display_bcd = a_q;
        case (state_q)
            S_B, S_REQ, S_BUSY: display_bcd = b_q;
            S_RES, S_ERR:       display_bcd = res_q;
            default:            display_bcd = a_q;
        endcase
    end

    assign operand_a   = a_q;
    assign operand_b   = b_q;
    assign opcode      = op_q;
    assign calc_valid  = (state_q == S_REQ);
    assign display_neg = (state_q == S_RES) && res_neg_q;
    assign display_err = (state_q == S_ERR);

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Directed bench for keypad_entry_ctrl: vector table of key presses plus multi-cycle corner sequences.
module tb_keypad_entry_ctrl;

    localparam int DB = 3;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  keycode = 4'h0;
    logic        keypressed = 1'b0;
    logic [15:0] operand_a, operand_b, display_bcd;
    logic [1:0]  opcode;
    logic        calc_valid, display_neg, display_err;
    logic        calc_ready = 1'b0;
    logic        result_valid = 1'b0;
    logic [15:0] result_bcd = 16'h0;
    logic        result_neg = 1'b0;
    logic        result_err = 1'b0;

    int tests = 0;
    int failures = 0;

    keypad_entry_ctrl #(.DIGITS(4), .DEBOUNCE_CYCLES(DB)) dut (
        .clock        (clock),
        .reset        (reset),
        .keycode      (keycode),
        .keypressed   (keypressed),
        .operand_a    (operand_a),
        .operand_b    (operand_b),
        .opcode       (opcode),
        .calc_valid   (calc_valid),
        .calc_ready   (calc_ready),
        .result_valid (result_valid),
        .result_bcd   (result_bcd),
        .result_neg   (result_neg),
        .result_err   (result_err),
        .display_bcd  (display_bcd),
        .display_neg  (display_neg),
        .display_err  (display_err)
    );

    always #5 clock = ~clock;

    // observe the request handshake independently of the stimulus thread
    logic        cv_clr = 1'b0;
    int          cv_cycles = 0;
    logic [15:0] hs_a = 16'h0, hs_b = 16'h0;
    logic [1:0]  hs_op = 2'b11;
    always @(posedge clock) begin
        if (cv_clr) cv_cycles <= 0;
        else if (calc_valid) cv_cycles <= cv_cycles + 1;
        if (calc_valid && calc_ready) begin
            hs_a  <= operand_a;
            hs_b  <= operand_b;
            hs_op <= opcode;
        end
    end

    typedef struct {
        logic [3:0]  key;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] disp;
        logic [1:0]  op;
        logic        cv;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic press(input logic [3:0] k);
        @(negedge clock);
        keycode    = k;
        keypressed = 1'b1;
        repeat (DB + 2) @(negedge clock);
        keypressed = 1'b0;
        repeat (DB + 3) @(negedge clock);
    endtask

    task automatic pulse_result(input logic [15:0] bcd, input logic neg, input logic err);
        @(negedge clock);
        result_bcd   = bcd;
        result_neg   = neg;
        result_err   = err;
        result_valid = 1'b1;
        @(negedge clock);
        result_valid = 1'b0;
        result_neg   = 1'b0;
        result_err   = 1'b0;
        @(negedge clock);
    endtask

    initial begin
        int lat;
        int stable;

        vecs.push_back('{4'h1, 16'h0001, 16'h0000, 16'h0001, 2'b00, 1'b0});
        vecs.push_back('{4'h2, 16'h0012, 16'h0000, 16'h0012, 2'b00, 1'b0});
        vecs.push_back('{4'hA, 16'h0012, 16'h0000, 16'h0012, 2'b00, 1'b0});
        vecs.push_back('{4'hC, 16'h0012, 16'h0000, 16'h0012, 2'b10, 1'b0});
        vecs.push_back('{4'hB, 16'h0012, 16'h0000, 16'h0012, 2'b01, 1'b0});
        vecs.push_back('{4'h7, 16'h0012, 16'h0007, 16'h0007, 2'b01, 1'b0});
        vecs.push_back('{4'hA, 16'h0012, 16'h0007, 16'h0007, 2'b01, 1'b0});
        vecs.push_back('{4'h3, 16'h0012, 16'h0073, 16'h0073, 2'b01, 1'b0});
        vecs.push_back('{4'hF, 16'h0012, 16'h0007, 16'h0007, 2'b01, 1'b0});
        vecs.push_back('{4'hD, 16'h0012, 16'h0007, 16'h0007, 2'b01, 1'b1});
        vecs.push_back('{4'h5, 16'h0012, 16'h0007, 16'h0007, 2'b01, 1'b1});
        vecs.push_back('{4'hE, 16'h0000, 16'h0000, 16'h0000, 2'b00, 1'b0});
        vecs.push_back('{4'h9, 16'h0009, 16'h0000, 16'h0009, 2'b00, 1'b0});
        vecs.push_back('{4'h8, 16'h0098, 16'h0000, 16'h0098, 2'b00, 1'b0});
        vecs.push_back('{4'h7, 16'h0987, 16'h0000, 16'h0987, 2'b00, 1'b0});
        vecs.push_back('{4'h6, 16'h9876, 16'h0000, 16'h9876, 2'b00, 1'b0});
        vecs.push_back('{4'h5, 16'h9876, 16'h0000, 16'h9876, 2'b00, 1'b0});
        vecs.push_back('{4'hF, 16'h0987, 16'h0000, 16'h0987, 2'b00, 1'b0});
        vecs.push_back('{4'hD, 16'h0987, 16'h0000, 16'h0987, 2'b00, 1'b0});
        vecs.push_back('{4'hA, 16'h0987, 16'h0000, 16'h0987, 2'b00, 1'b0});
        vecs.push_back('{4'hF, 16'h0987, 16'h0000, 16'h0987, 2'b00, 1'b0});
        vecs.push_back('{4'h0, 16'h9870, 16'h0000, 16'h9870, 2'b00, 1'b0});
        vecs.push_back('{4'hE, 16'h0000, 16'h0000, 16'h0000, 2'b00, 1'b0});
        vecs.push_back('{4'h0, 16'h0000, 16'h0000, 16'h0000, 2'b00, 1'b0});
        vecs.push_back('{4'hF, 16'h0000, 16'h0000, 16'h0000, 2'b00, 1'b0});
        vecs.push_back('{4'hC, 16'h0000, 16'h0000, 16'h0000, 2'b10, 1'b0});

        // reset state
        repeat (3) @(negedge clock);
        check("rst operand_a", operand_a, 16'h0);
        check("rst operand_b", operand_b, 16'h0);
        check("rst opcode", opcode, 2'b00);
        check("rst calc_valid", calc_valid, 1'b0);
        check("rst display_bcd", display_bcd, 16'h0);
        check("rst display_neg", display_neg, 1'b0);
        check("rst display_err", display_err, 1'b0);
        reset = 1'b0;
        @(negedge clock);

        // table: calc_ready held low so S_REQ stays visible
        for (int i = 0; i < vecs.size(); i++) begin
            press(vecs[i].key);
            check($sformatf("vec%0d operand_a", i), operand_a, vecs[i].a);
            check($sformatf("vec%0d operand_b", i), operand_b, vecs[i].b);
            check($sformatf("vec%0d opcode", i), opcode, vecs[i].op);
            check($sformatf("vec%0d display_bcd", i), display_bcd, vecs[i].disp);
            check($sformatf("vec%0d calc_valid", i), calc_valid, vecs[i].cv);
            check($sformatf("vec%0d display_neg", i), display_neg, 1'b0);
        end

        // 12 + 7 with a one-cycle handshake, then result 19
        press(4'hE);
        calc_ready = 1'b1;
        press(4'h1); press(4'h2); press(4'hA); press(4'h7);
        @(negedge clock); cv_clr = 1'b1;
        @(negedge clock); cv_clr = 1'b0;
        press(4'hD);
        check("req cycles", cv_cycles, 1);
        check("req operand_a", hs_a, 16'h0012);
        check("req operand_b", hs_b, 16'h0007);
        check("req opcode", hs_op, 2'b00);
        check("busy calc_valid", calc_valid, 1'b0);
        check("busy display", display_bcd, 16'h0007);
        pulse_result(16'h0019, 1'b0, 1'b0);
        check("res display_bcd", display_bcd, 16'h0019);
        check("res display_neg", display_neg, 1'b0);
        check("res display_err", display_err, 1'b0);
        pulse_result(16'h0055, 1'b0, 1'b0);
        check("res late strobe", display_bcd, 16'h0019);
        press(4'hB);
`ifdef CALC_CHAIN_EN
        check("chain operand_a", operand_a, 16'h0019);
        check("chain opcode", opcode, 2'b01);
        check("chain display", display_bcd, 16'h0019);
        press(4'h4);
        check("chain operand_b", operand_b, 16'h0004);
`else
        check("nochain operand_a", operand_a, 16'h0012);
        check("nochain opcode", opcode, 2'b00);
        check("nochain display", display_bcd, 16'h0019);
`endif

        // negative result, key dropped while busy, digit restarts entry
        press(4'hE);
        press(4'h3); press(4'hB); press(4'h5); press(4'hD);
        press(4'h7);
        check("busy drop operand_b", operand_b, 16'h0005);
        pulse_result(16'h0002, 1'b1, 1'b0);
        check("neg display_bcd", display_bcd, 16'h0002);
        check("neg display_neg", display_neg, 1'b1);
        press(4'h4);
        check("restart operand_a", operand_a, 16'h0004);
        check("restart operand_b", operand_b, 16'h0000);
        check("restart display", display_bcd, 16'h0004);
        check("restart display_neg", display_neg, 1'b0);

        // 2-cycle glitch and a code change mid-hold produce no strobe
        @(negedge clock); keycode = 4'h3; keypressed = 1'b1;
        repeat (2) @(negedge clock); keypressed = 1'b0;
        repeat (10) @(negedge clock);
        check("glitch operand_a", operand_a, 16'h0004);
        keypressed = 1'b1;
        repeat (2) @(negedge clock); keycode = 4'h6;
        repeat (2) @(negedge clock); keypressed = 1'b0;
        repeat (10) @(negedge clock);
        check("code change operand_a", operand_a, 16'h0004);

        // press-to-register latency
        press(4'hE);
        @(negedge clock); keycode = 4'h6; keypressed = 1'b1;
        lat = 0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clock); #1;
            if (lat == 0 && operand_a != 16'h0) lat = i;
        end
        check("press latency", lat, DB + 1);
        @(negedge clock); keypressed = 1'b0;
        repeat (DB + 3) @(negedge clock);
        check("latency operand_a", operand_a, 16'h0006);

        // long hold yields one digit
        press(4'hE);
        @(negedge clock); keycode = 4'h5; keypressed = 1'b1;
        repeat (50) @(negedge clock); keypressed = 1'b0;
        repeat (DB + 3) @(negedge clock);
        check("long hold operand_a", operand_a, 16'h0005);

        // request held off by calc_ready, then aborted by clear
        press(4'hE);
        calc_ready = 1'b0;
        press(4'h1); press(4'hA); press(4'h2); press(4'hD);
        stable = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (calc_valid === 1'b1 && operand_a === 16'h0001 && operand_b === 16'h0002
                && opcode === 2'b00) stable++;
        end
        check("req hold stable cycles", stable, 10);
        press(4'hE);
        check("abort calc_valid", calc_valid, 1'b0);
        check("abort display", display_bcd, 16'h0000);
        check("abort operand_b", operand_b, 16'h0000);
        pulse_result(16'h0055, 1'b0, 1'b0);
        check("idle result ignored", display_bcd, 16'h0000);

        // error result locks out everything but clear
        calc_ready = 1'b1;
        press(4'h9); press(4'hC); press(4'h9); press(4'hD);
        pulse_result(16'h0081, 1'b0, 1'b1);
        check("err display_err", display_err, 1'b1);
        check("err display_neg", display_neg, 1'b0);
        press(4'h3);
        check("err digit ignored", operand_a, 16'h0009);
        check("err still flagged", display_err, 1'b1);
        press(4'hE);
        check("err cleared", display_err, 1'b0);
        check("err clear operand_a", operand_a, 16'h0000);
        check("err clear opcode", opcode, 2'b00);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
